lockpick_hash_arbiter: RTL and testbench

- Sequencer and arbiter that shares one iterative Feistel hash round between two independent lockpick requesters (player slots 0 and 1).
- Grants one requester at a time, round-robin, then loads that requester's 256-bit key.
- Steps the shared round datapath once per clock for N_ROUNDS cycles.
- Returns the 256-bit digest plus a target-match flag through a per-requester req/done handshake.
- Replaces per-game combinational hashing, so the game FSMs become clients of a single hash engine.

---
 rtl/lockpick_pkg.sv | 45 ++++
 rtl/lockpick_hash_arbiter_if.sv | 16 +
 rtl/lockpick_feistel_round.sv | 28 ++
 rtl/lockpick_hash_arbiter.sv | 118 +++++++++++
 tb/tb_lockpick_hash_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lockpick_pkg.sv
// Shared declarations for the lockpick hash engine: FSM states, AES S-box, permutation.
// Latency: none; functions here are purely combinational.
// Backpressure: not applicable; no storage or handshakes live in this package.
package lockpick_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  localparam logic [255:0] DEFAULT_TARGET =
    256'hCAFEBABE12345678DEADBEEFFEEDFACEC001D00DBADC0DE5BAADF00D0BADBEEF;

  // AES S-box; entry 0 sits in the most significant byte.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset 8*(255-x), and 255-x is simply ~x for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return AES_SBOX[{~x, 3'b000} +: 8];
  endfunction

  // Rotate every byte left by one, then the whole word left by 13.
  function automatic logic [63:0] permute(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = {w[8*i +: 7], w[8*i+7]};
    end
    return {r[50:0], r[63:51]};
  endfunction

  function automatic logic [63:0] sub_bytes(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = sbox(w[8*i +: 8]);
    end
    return r;
  endfunction

endpackage

// File: rtl/lockpick_hash_arbiter_if.sv
// Bundle between the two lockpick requesters and the shared hash engine.
// Latency: wires only.
// Backpressure: req is held until the matching done pulse; keys stay stable meanwhile.
interface lockpick_hash_arbiter_if;
  logic [1:0]   req;
  logic [255:0] key0;
  logic [255:0] key1;
  logic [1:0]   done;
  logic [255:0] result;
  logic         match;
  logic         busy;
  logic         grant_id;

  modport master (output req, key0, key1, input done, result, match, busy, grant_id);
  modport slave  (input req, key0, key1, output done, result, match, busy, grant_id);
endinterface

// File: rtl/lockpick_feistel_round.sv
// One Feistel round over the 256-bit {A,B,C,D} state, all lanes mod 2^64.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the output.
module lockpick_feistel_round
  import lockpick_pkg::*;
(
  input  logic [255:0] st_i,
  output logic [255:0] st_o
);

  logic [63:0] a, b, c, d;
  logic [63:0] f_mix, f_sub, a_x, a_r, b_r, c_n, d_n;

  assign {a, b, c, d} = st_i;

  assign f_mix = ((b ^ d) + (a | c)) ^ {c[31:0], d[31:0]};
  assign f_sub = sub_bytes(permute(f_mix));

  // C consumes A after the xor but before A's final rotation; D uses the rotated B.
  assign a_x = a ^ f_sub;
  assign b_r = {b[30:0], b[63:31]};
  assign c_n = c + a_x;
  assign d_n = ~d ^ b_r;
  assign a_r = {a_x[47:0], a_x[63:48]};

  assign st_o = {a_r, b_r, c_n, d_n};

endmodule

// File: rtl/lockpick_hash_arbiter.sv
// Round-robin arbiter sharing one iterative Feistel round between two requesters.
// Latency: req seen in IDLE at cycle t gives done at t+N_ROUNDS+2; one hash per N_ROUNDS+3.
// Backpressure: losers wait with req held; dropping req[grant] mid-hash aborts silently.
module lockpick_hash_arbiter
  import lockpick_pkg::*;
#(
  parameter int unsigned  N_ROUNDS = 3,
  parameter logic [255:0] TARGET   = DEFAULT_TARGET
) (
  input  logic clk,
  input  logic rst_n,
  lockpick_hash_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_RND = 4'(N_ROUNDS - 1);

  state_t       state_q, state_d;
  logic         grant_id_q, grant_id_d;
  logic         last_grant_q, last_grant_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [255:0] st_q, st_d;
  logic [1:0]   done_q, done_d;
  logic [255:0] result_q, result_d;
  logic         match_q, match_d;
  logic         busy_q, busy_d;
  logic         winner;
  logic [255:0] round_out;

  lockpick_feistel_round u_round (
    .st_i (st_q),
    .st_o (round_out)
  );

  // Next-state, arbitration and datapath-enable decisions.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    rcnt_d       = rcnt_q;
    st_d         = st_q;
    done_d       = 2'b00;
    result_d     = result_q;
    match_d      = match_q;
    // Single requester wins outright; on contention the one not served last wins.
    winner       = (bus.req == 2'b11) ? ~last_grant_q : bus.req[1];
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          grant_id_d   = winner;
          last_grant_d = winner;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (!bus.req[grant_id_q]) begin
          state_d = IDLE;
        end else begin
          st_d    = grant_id_q ? bus.key1 : bus.key0;
          rcnt_d  = 4'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (!bus.req[grant_id_q]) begin
          state_d = IDLE;
        end else begin
          st_d   = round_out;
          rcnt_d = rcnt_q + 4'd1;
          if (rcnt_q == LAST_RND) begin
            state_d            = DONE;
            done_d[grant_id_q] = 1'b1;
            result_d           = round_out;
            match_d            = (round_out == TARGET);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Arbitration memory, round state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      rcnt_q       <= 4'd0;
      st_q         <= '0;
      done_q       <= 2'b00;
      result_q     <= '0;
      match_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rcnt_q       <= rcnt_d;
      st_q         <= st_d;
      done_q       <= done_d;
      result_q     <= result_d;
      match_q      <= match_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.match    = match_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_lockpick_hash_arbiter.sv
// Scoreboard bench for lockpick_hash_arbiter: three instances (3 rounds, 1 round, custom target).
// Clients push expected digests at request time; a negedge monitor pops and compares on done.
// Every wait for a done pulse is bounded; an expired bound counts as a failure.
module tb_lockpick_hash_arbiter;

  localparam logic [255:0] SPEC_TARGET =
    256'hCAFEBABE12345678DEADBEEFFEEDFACEC001D00DBADC0DE5BAADF00D0BADBEEF;
  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam int BUDGET = 40;

  // Reference digest: the round rules applied sequentially to plain 64-bit variables.
  function automatic logic [255:0] ref_hash(input logic [255:0] key, input int rounds);
    logic [63:0] a, b, c, d, f, t;
    logic [7:0]  bv;
    {a, b, c, d} = key;
    for (int r = 0; r < rounds; r++) begin
      f = ((b ^ d) + (a | c)) ^ {c[31:0], d[31:0]};
      t = 64'd0;
      for (int i = 0; i < 8; i++) begin
        bv = f[8*i +: 8];
        t[8*i +: 8] = (bv << 1) | (bv >> 7);
      end
      t = (t << 13) | (t >> 51);
      for (int i = 0; i < 8; i++) begin
        bv = t[8*i +: 8];
        f[8*i +: 8] = SB[2047 - 8*int'(bv) -: 8];
      end
      a = a ^ f;
      b = (b << 33) | (b >> 31);
      c = c + a;
      d = ~d ^ b;
      a = (a << 16) | (a >> 48);
    end
    return {a, b, c, d};
  endfunction

  localparam logic [255:0] MATCH_TGT = ref_hash(256'h1, 3);

  typedef struct {
    logic [255:0] res;
    logic         mt;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic         req_v [3][2];
  logic [255:0] key_v [3][2];
  exp_t         exp_q [6][$];
  int           done_cnt [6];
  int           busy_cnt [3];

  logic [1:0]   done_w  [3];
  logic [255:0] res_w   [3];
  logic         match_w [3];
  logic         busy_w  [3];
  logic         gid_w   [3];

  lockpick_hash_arbiter_if bus0 ();
  lockpick_hash_arbiter_if bus1 ();
  lockpick_hash_arbiter_if bus2 ();

  assign bus0.req = {req_v[0][1], req_v[0][0]};
  assign bus1.req = {req_v[1][1], req_v[1][0]};
  assign bus2.req = {req_v[2][1], req_v[2][0]};
  assign bus0.key0 = key_v[0][0];
  assign bus0.key1 = key_v[0][1];
  assign bus1.key0 = key_v[1][0];
  assign bus1.key1 = key_v[1][1];
  assign bus2.key0 = key_v[2][0];
  assign bus2.key1 = key_v[2][1];

  assign done_w[0] = bus0.done;    assign done_w[1] = bus1.done;    assign done_w[2] = bus2.done;
  assign res_w[0] = bus0.result;   assign res_w[1] = bus1.result;   assign res_w[2] = bus2.result;
  assign match_w[0] = bus0.match;  assign match_w[1] = bus1.match;  assign match_w[2] = bus2.match;
  assign busy_w[0] = bus0.busy;    assign busy_w[1] = bus1.busy;    assign busy_w[2] = bus2.busy;
  assign gid_w[0] = bus0.grant_id; assign gid_w[1] = bus1.grant_id; assign gid_w[2] = bus2.grant_id;

  lockpick_hash_arbiter #(.N_ROUNDS(3)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  lockpick_hash_arbiter #(.N_ROUNDS(1)) u_dut_r1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  lockpick_hash_arbiter #(.N_ROUNDS(3), .TARGET(MATCH_TGT)) u_dut_tgt (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rounds_of(input int n);
    return (n == 1) ? 1 : 3;
  endfunction

  function automatic logic [255:0] target_of(input int n);
    return (n == 2) ? MATCH_TGT : SPEC_TARGET;
  endfunction

  function automatic logic [255:0] rand_key();
    if ($urandom_range(0, 7) == 0) return '1;
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Client: raise req, queue the expected response, hold until done (bounded), then drop.
  // due_off is the required done cycle relative to the raise cycle, or -1 when not fixed.
  task automatic request(input int n, input int id, input logic [255:0] key, input int due_off);
    exp_t e;
    int   qi;
    int   start;
    int   waited;
    qi = n*2 + id;
    key_v[n][id] = key;
    req_v[n][id] = 1'b1;
    e.res = ref_hash(key, rounds_of(n));
    e.mt  = (e.res == target_of(n));
    e.due = (due_off < 0) ? -1 : cyc + due_off;
    exp_q[qi].push_back(e);
    start  = done_cnt[qi];
    waited = 0;
    while (done_cnt[qi] == start && waited < BUDGET) begin
      tick(1);
      waited++;
    end
    chk_int($sformatf("done_arrived[%0d.%0d]", n, id), int'(done_cnt[qi] != start), 1);
    if (done_cnt[qi] == start) exp_q[qi].delete();
    req_v[n][id] = 1'b0;
  endtask

  // Monitor: one-hot done, then pop that requester's expectation and compare.
  task automatic observe(input int n);
    exp_t e;
    int   id;
    int   qi;
    if (busy_w[n]) busy_cnt[n]++;
    if (done_w[n] != 2'b00) begin
      chk_int($sformatf("done_onehot[%0d]", n), int'(done_w[n] != 2'b11), 1);
      id = int'(done_w[n][1]);
      qi = n*2 + id;
      done_cnt[qi]++;
      chk_int($sformatf("done_expected[%0d.%0d]", n, id), int'(exp_q[qi].size() > 0), 1);
      if (exp_q[qi].size() > 0) begin
        e = exp_q[qi].pop_front();
        chk_vec($sformatf("result[%0d.%0d]", n, id), res_w[n], e.res);
        chk_int($sformatf("match[%0d.%0d]", n, id), int'(match_w[n]), int'(e.mt));
        chk_int($sformatf("grant_id_at_done[%0d.%0d]", n, id), int'(gid_w[n]), id);
        if (e.due >= 0) chk_int($sformatf("done_cycle[%0d.%0d]", n, id), cyc, e.due);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int n = 0; n < 3; n++) observe(n);
      end
    end
  end

  initial begin
    int b0;
    int d0;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2; i++) begin
        req_v[n][i] = 1'b0;
        key_v[n][i] = '0;
      end
    end
    for (int i = 0; i < 6; i++) done_cnt[i] = 0;
    for (int i = 0; i < 3; i++) busy_cnt[i] = 0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset values.
    chk_int("rst_done", int'(bus0.done), 0);
    chk_int("rst_busy", int'(bus0.busy), 0);
    chk_int("rst_match", int'(bus0.match), 0);
    chk_int("rst_grant_id", int'(bus0.grant_id), 0);
    chk_vec("rst_result", bus0.result, '0);

    // Contention from reset: order 0,1,0,1 with done pulses 6 cycles apart.
    fork
      begin request(0, 0, rand_key(), 5); request(0, 0, rand_key(), 11); end
      begin request(0, 1, rand_key(), 11); request(0, 1, rand_key(), 11); end
    join
    tick(2);

    // Single request of key 0: done 5 cycles later, busy for LOAD+3xROUND+DONE.
    b0 = busy_cnt[0];
    request(0, 0, '0, 5);
    tick(2);
    chk_int("busy_cycles_n3", busy_cnt[0] - b0, 5);

    // Abort: req0 drops in its 2nd ROUND cycle; req1 (raised later) is served next.
    d0 = done_cnt[0];
    fork
      begin
        key_v[0][0] = rand_key();
        req_v[0][0] = 1'b1;
        tick(3);
        req_v[0][0] = 1'b0;
      end
      begin
        tick(1);
        request(0, 1, rand_key(), 8);
      end
    join
    tick(2);
    chk_int("abort_no_done0", done_cnt[0] - d0, 0);

    // Reset in the middle of ROUND while requester 1 is being served.
    key_v[0][1] = rand_key();
    req_v[0][1] = 1'b1;
    tick(3);
    chk_int("pre_reset_grant_id", int'(bus0.grant_id), 1);
    rst_n = 1'b0;
    req_v[0][1] = 1'b0;
    #1;
    chk_int("midrst_done", int'(bus0.done), 0);
    chk_int("midrst_busy", int'(bus0.busy), 0);
    chk_int("midrst_grant_id", int'(bus0.grant_id), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    fork
      request(0, 0, rand_key(), 5);
      request(0, 1, rand_key(), 11);
    join
    tick(2);

    // Randomised traffic from both requesters with random idle gaps.
    fork
      for (int j = 0; j < 8; j++) begin
        tick($urandom_range(0, 3));
        request(0, 0, rand_key(), -1);
      end
      for (int j = 0; j < 8; j++) begin
        tick($urandom_range(0, 3));
        request(0, 1, rand_key(), -1);
      end
    join
    tick(2);

    // Single-round instance: done 3 cycles after sampling.
    b0 = busy_cnt[1];
    request(1, 0, '0, 3);
    tick(2);
    chk_int("busy_cycles_n1", busy_cnt[1] - b0, 3);
    request(1, 1, rand_key(), 3);
    tick(2);

    // Target set to the digest of key 1: key1=1 must match, key1=2 must not.
    request(2, 1, 256'h1, 5);
    tick(1);
    request(2, 1, 256'h2, 5);
    tick(3);

    for (int i = 0; i < 6; i++) chk_int($sformatf("queue_drained[%0d]", i), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
